rf_multiport_sb: RTL

//  Parametrised successor register file for the pipelined MIPS32 core: NRD combinational read ports,
//  one write port with same-cycle write-through, optional hardwired-zero entry 0. Adds a pending-write

---
 rtl/rf_multiport_sb_pkg.sv | 22 ++
 rtl/rf_multiport_sb_scoreboard.sv | 56 +++++
 rtl/rf_multiport_sb.sv | 112 +++++++++++
 3 files changed

// File: rtl/rf_multiport_sb_pkg.sv
// Shared definitions for the multiport register file: FSM encoding,
// default geometry and port-slicing helpers.
package rf_pkg;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_e;

    localparam int RF_AW_DEFAULT = 5;
    localparam int DEPTH         = 1 << RF_AW_DEFAULT;

    function automatic int rf_depth(input int aw);
        return 1 << aw;
    endfunction

    // Low bit of port k inside a flattened bus of w-bit fields.
    function automatic int slice_lo(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/rf_multiport_sb_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback, with a read-side bypass so a value being forwarded is not pending.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_i,
    input  logic              flush_i,
    input  logic              set_en_i,
    input  logic [AW-1:0]     set_addr_i,
    input  logic              clr_en_i,
    input  logic [AW-1:0]     clr_addr_i,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD-1:0]    rd_pend_o,
    output logic              pend_any_o
);

    localparam int  SB_DEPTH = rf_depth(AW);
    localparam bit  HAS_ZERO = (ZERO_REG != 0);

    logic [SB_DEPTH-1:0] pend_q;
    logic [SB_DEPTH-1:0] pend_d;

    // Set is applied after clear so a new producer issued as the old one retires stays pending.
    always_comb begin
        pend_d = pend_q;
        if (run_i) begin
            if (flush_i) begin
                pend_d = '0;
            end else begin
                if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
                if (set_en_i) pend_d[set_addr_i] = 1'b1;
            end
        end
        if (HAS_ZERO) pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr         = rd_addr_i[slice_lo(k, AW) +: AW];
        assign rd_pend_o[k] = run_i & pend_q[addr] & ~(clr_en_i && (clr_addr_i == addr));
    end

    assign pend_any_o = |pend_q;

endmodule

// File: rtl/rf_multiport_sb.sv
// Multiport register file with write-through reads, optional hardwired r0,
// pending-write scoreboard and a one-entry-per-cycle clear sweep.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_req_i,
    output logic              busy_o,
    input  logic [NRD*AW-1:0] rd_addr_i,
    output logic [NRD*DW-1:0] rd_data_o,
    output logic [NRD-1:0]    rd_pend_o,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [DW-1:0]     wr_data_i,
    input  logic              iss_en_i,
    input  logic [AW-1:0]     iss_addr_i,
    output logic              pend_any_o
);

    localparam int            RF_DEPTH  = rf_depth(AW);
    localparam bit            HAS_ZERO  = (ZERO_REG != 0);
    localparam logic [AW-1:0] PTR_START = HAS_ZERO ? AW'(1) : '0;
    localparam logic [AW-1:0] PTR_LAST  = AW'(RF_DEPTH - 1);

    rf_state_e     state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [DW-1:0] mem_q [RF_DEPTH];
    logic          run;
    logic          clr_go;
    logic          mem_we;

    assign run    = (state_q == RF_RUN);
    assign clr_go = run && clr_req_i;
    assign mem_we = run && !clr_req_i && wr_en_i && !(HAS_ZERO && (wr_addr_i == '0));
    assign busy_o = !run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RF_CLEAR;
            ptr_q   <= PTR_START;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // The pointer stops at the last entry, so it never wraps.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            RF_CLEAR: begin
                if (ptr_q == PTR_LAST) state_d = RF_RUN;
                else                   ptr_d   = ptr_q + AW'(1);
            end
            RF_RUN: begin
                if (clr_req_i) begin
                    state_d = RF_CLEAR;
                    ptr_d   = PTR_START;
                end
            end
            default: begin
                state_d = RF_CLEAR;
                ptr_d   = PTR_START;
            end
        endcase
    end

    // No reset on the array so it can map to distributed RAM; the sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (!run)        mem_q[ptr_q]     <= '0;
        else if (mem_we) mem_q[wr_addr_i] <= wr_data_i;
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        assign addr = rd_addr_i[slice_lo(k, AW) +: AW];
        always_comb begin
            data = mem_q[addr];
            if (!run)                                    data = '0;
            else if (HAS_ZERO && (addr == '0))           data = '0;
            else if (wr_en_i && (wr_addr_i == addr))     data = wr_data_i;
        end
        assign rd_data_o[slice_lo(k, DW) +: DW] = data;
    end

    rf_scoreboard #(
        .AW       (AW),
        .NRD      (NRD),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .run_i      (run),
        .flush_i    (clr_go),
        .set_en_i   (iss_en_i),
        .set_addr_i (iss_addr_i),
        .clr_en_i   (wr_en_i),
        .clr_addr_i (wr_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rd_pend_o  (rd_pend_o),
        .pend_any_o (pend_any_o)
    );

endmodule
